// File: rtl/alarm_unit_pkg.sv
// ============================================================
// alarm_unit_pkg: shared FSM state type, BCD limits and defaults
// Rev 1.0
// ============================================================
`default_nettype none

package alarm_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SET    = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  localparam logic [7:0] c_HR_MAX  = 8'h23;
  localparam logic [7:0] c_MIN_MAX = 8'h59;

  localparam int c_CLK_HZ_DEF     = 100_000_000;
  localparam int c_TONE_HZ_DEF    = 2000;
  localparam int c_BLINK_HZ_DEF   = 2;
  localparam int c_RING_SEC_DEF   = 60;
  localparam int c_SNOOZE_SEC_DEF = 300;

  // Two-digit BCD increment that wraps to 00 after max (no carry out).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_tone_gen.sv
// ============================================================
// alarm_tone_gen: free-running prescalers for buzzer tone and LED blink
// Rev 1.0
// ============================================================
`default_nettype none

module alarm_tone_gen
  import alarm_unit_pkg::*;
#(
  parameter int CLK_HZ   = c_CLK_HZ_DEF,
  parameter int TONE_HZ  = c_TONE_HZ_DEF,
  parameter int BLINK_HZ = c_BLINK_HZ_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic o_tone,
  output logic o_blink
);

  localparam int c_TONE_HALF  = (CLK_HZ / (2 * TONE_HZ) > 1) ? CLK_HZ / (2 * TONE_HZ) : 1;
  localparam int c_BLINK_HALF = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int c_TONE_W     = (c_TONE_HALF > 1) ? $clog2(c_TONE_HALF) : 1;
  localparam int c_BLINK_W    = (c_BLINK_HALF > 1) ? $clog2(c_BLINK_HALF) : 1;
  localparam logic [c_TONE_W-1:0]  c_TONE_LAST  = c_TONE_W'(c_TONE_HALF - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(c_BLINK_HALF - 1);

  logic [c_TONE_W-1:0]  r_tone_cnt;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic                 r_tone;
  logic                 r_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == c_TONE_LAST) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign o_tone  = r_tone;
  assign o_blink = r_blink;

endmodule

`default_nettype wire

// File: rtl/alarm_unit.sv
// ============================================================
// alarm_unit: alarm-time storage, match/trigger, ring/snooze FSM
// Rev 1.0
// ============================================================
`default_nettype none

module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int CLK_HZ     = c_CLK_HZ_DEF,
  parameter int TONE_HZ    = c_TONE_HZ_DEF,
  parameter int BLINK_HZ   = c_BLINK_HZ_DEF,
  parameter int RING_SEC   = c_RING_SEC_DEF,
  parameter int SNOOZE_SEC = c_SNOOZE_SEC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       hr_up,
  input  logic       min_up,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] ah2,
  output logic [3:0] ah1,
  output logic [3:0] am2,
  output logic [3:0] am1,
  output logic       ringing,
  output logic       buzzer,
  output logic       alarm_led
);

  localparam int c_CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_RING_LAST   = c_CNT_W'(RING_SEC - 1);
  localparam logic [c_CNT_W-1:0] c_SNOOZE_LAST = c_CNT_W'(SNOOZE_SEC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_s1_q;
  logic                 r_tick_en;
  logic                 r_match_q;
  logic [c_CNT_W-1:0]   r_sec_cnt;
  logic [7:0]           r_alarm_hr;
  logic [7:0]           r_alarm_min;
  logic                 r_ringing;
  logic                 r_buzzer;
  logic                 r_led;
  logic                 w_tick;
  logic                 w_match;
  logic                 w_trigger;
  logic                 w_tone;
  logic                 w_blink;
  logic                 w_ringing_nxt;
  logic                 w_buzzer_nxt;
  logic                 w_led_nxt;

  alarm_tone_gen #(
    .CLK_HZ   (CLK_HZ),
    .TONE_HZ  (TONE_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) u_tone_gen (
    .clk     (clk),
    .reset   (reset),
    .o_tone  (w_tone),
    .o_blink (w_blink)
  );

  // The first cycle after reset has no valid previous seconds digit.
  assign w_tick    = r_tick_en & (s1 != r_s1_q);
  assign w_match   = alarm_en & ({h2, h1, m2, m1} == {r_alarm_hr, r_alarm_min}) & ({s2, s1} == 8'h00);
  assign w_trigger = w_match & ~r_match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_s1_q    <= 4'd0;
      r_tick_en <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s1_q    <= s1;
      r_tick_en <= 1'b1;
      r_match_q <= w_match;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (set_mode)       w_state_nxt = ST_SET;
        else if (w_trigger) w_state_nxt = ST_RING;
      end
      ST_SET: begin
        if (!set_mode) w_state_nxt = ST_IDLE;
      end
      ST_RING: begin
        if (set_mode)                                w_state_nxt = ST_SET;
        else if (!alarm_en || stop)                  w_state_nxt = ST_IDLE;
        else if (snooze)                             w_state_nxt = ST_SNOOZE;
        else if (w_tick && r_sec_cnt == c_RING_LAST) w_state_nxt = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (set_mode)                                  w_state_nxt = ST_SET;
        else if (!alarm_en || stop)                    w_state_nxt = ST_IDLE;
        else if (w_tick && r_sec_cnt == c_SNOOZE_LAST) w_state_nxt = ST_RING;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ringing_nxt = (w_state_nxt == ST_RING);
    w_buzzer_nxt  = (w_state_nxt == ST_RING) & w_tone;
    w_led_nxt     = 1'b0;
    case (w_state_nxt)
      ST_IDLE:   w_led_nxt = alarm_en;
      ST_SET:    w_led_nxt = 1'b0;
      ST_RING:   w_led_nxt = w_blink;
      ST_SNOOZE: w_led_nxt = 1'b1;
      default:   w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ringing <= 1'b0;
      r_buzzer  <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_ringing <= w_ringing_nxt;
      r_buzzer  <= w_buzzer_nxt;
      r_led     <= w_led_nxt;
    end
  end

  // One counter serves both RING and SNOOZE; any state change restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_sec_cnt <= '0;
    end else if (w_tick && (r_state == ST_RING || r_state == ST_SNOOZE)) begin
      r_sec_cnt <= r_sec_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm_hr  <= 8'h00;
      r_alarm_min <= 8'h00;
    end else if (r_state == ST_SET) begin
      if (hr_up)  r_alarm_hr  <= bcd_inc(r_alarm_hr, c_HR_MAX);
      if (min_up) r_alarm_min <= bcd_inc(r_alarm_min, c_MIN_MAX);
    end
  end

  assign ah2       = r_alarm_hr[7:4];
  assign ah1       = r_alarm_hr[3:0];
  assign am2       = r_alarm_min[7:4];
  assign am1       = r_alarm_min[3:0];
  assign ringing   = r_ringing;
  assign buzzer    = r_buzzer;
  assign alarm_led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_alarm_unit.sv
// ============================================================
// tb_alarm_unit: scoreboard-driven bench for alarm_unit
// Rev 1.0
// ============================================================
`default_nettype none

module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] h2 = 4'd0, h1 = 4'd0, m2 = 4'd0, m1 = 4'd0, s2 = 4'd0, s1 = 4'd0;
  logic       alarm_en = 1'b0, set_mode = 1'b0, hr_up = 1'b0, min_up = 1'b0;
  logic       stop = 1'b0, snooze = 1'b0;
  logic [3:0] ah2, ah1, am2, am1;
  logic       ringing, buzzer, alarm_led;

  localparam logic [18:0] M_RING = 19'h40000;
  localparam logic [18:0] M_LED  = 19'h20000;
  localparam logic [18:0] M_BUZ  = 19'h10000;
  localparam logic [18:0] M_ALM  = 19'h0FFFF;
  localparam logic [18:0] M_ALL  = 19'h7FFFF;

  typedef struct {
    string       name;
    logic [18:0] mask;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_err = 0;
  int   n_chk = 0;

  alarm_unit #(
    .CLK_HZ(1000), .TONE_HZ(100), .BLINK_HZ(10), .RING_SEC(5), .SNOOZE_SEC(10)
  ) dut (
    .clk(clk), .reset(reset),
    .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .alarm_en(alarm_en), .set_mode(set_mode), .hr_up(hr_up), .min_up(min_up),
    .stop(stop), .snooze(snooze),
    .ah2(ah2), .ah1(ah1), .am2(am2), .am1(am1),
    .ringing(ringing), .buzzer(buzzer), .alarm_led(alarm_led)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {ringing, alarm_led, buzzer, ah2, ah1, am2, am1};
  endfunction

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    h2 = 4'(h / 10); h1 = 4'(h % 10);
    m2 = 4'(m / 10); m1 = 4'(m % 10);
    s2 = 4'(s / 10); s1 = 4'(s % 10);
  endtask

  task automatic pulse_hr();
    hr_up = 1'b1; step(); hr_up = 1'b0;
  endtask

  task automatic pulse_min();
    min_up = 1'b1; step(); min_up = 1'b0;
  endtask

  // Alarm must already be 07:30 and enabled; returns one cycle after the trigger edge.
  task automatic do_trigger();
    set_time(7, 29, 59); step(); step();
    set_time(7, 30, 0);  step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    sb.push_back('{"reset_outputs", M_ALL, 19'h0});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    reset = 1'b0;
    sb.push_back('{"after_reset_idle", M_ALL, 19'h0});
    step(); step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_set();
    int hr = 0;
    int mn = 0;
    set_mode = 1'b1;
    sb.push_back('{"set_led_off", M_LED | M_RING, 19'h0});
    step(); step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    repeat (7)  begin pulse_hr();  hr = (hr + 1) % 24; end
    repeat (30) begin pulse_min(); mn = (mn + 1) % 60; end
    sb.push_back('{"set_0730", M_ALM, {3'b0, bcd2(hr), bcd2(mn)}});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    repeat (60) begin pulse_min(); mn = (mn + 1) % 60; end
    sb.push_back('{"min_wrap_no_carry", M_ALM, {3'b0, bcd2(hr), bcd2(mn)}});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    repeat (17) begin pulse_hr(); hr = (hr + 1) % 24; end
    sb.push_back('{"hr_wrap_0030", M_ALM, {3'b0, bcd2(hr), bcd2(mn)}});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    hr_up = 1'b1; min_up = 1'b1; step(); hr_up = 1'b0; min_up = 1'b0;
    hr = (hr + 1) % 24; mn = (mn + 1) % 60;
    sb.push_back('{"both_pulses", M_ALM, {3'b0, bcd2(hr), bcd2(mn)}});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    repeat (6)  begin pulse_hr();  hr = (hr + 1) % 24; end
    repeat (59) begin pulse_min(); mn = (mn + 1) % 60; end
    set_mode = 1'b0; step(); step();
    pulse_hr(); pulse_min(); step();
    sb.push_back('{"ignored_outside_set", M_ALM | M_LED, {3'b0, bcd2(hr), bcd2(mn)}});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_trigger();
    logic prev;
    int   last = -1;
    int   ntog = 0;
    alarm_en = 1'b1;
    set_time(7, 29, 59); step(); step();
    sb.push_back('{"no_ring_before", M_RING | M_LED, M_LED});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    set_time(7, 30, 0);
    sb.push_back('{"ring_next_cycle", M_RING, M_RING});
    step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    prev = buzzer;
    for (int c = 0; c < 40; c++) begin
      step();
      if (buzzer !== prev) begin
        if (last >= 0) begin
          n_chk++;
          if (c - last !== 5) begin n_err++; $display("FAIL buzz_period: got %0d clks want 5", c - last); end
        end
        last = c; ntog++; prev = buzzer;
      end
    end
    n_chk++;
    if (ntog < 7) begin n_err++; $display("FAIL buzz_toggles: got %0d want >= 7", ntog); end

    for (int i = 1; i <= 4; i++) begin set_time(7, 30, i); step(); step(); end
    sb.push_back('{"ring_after_4_ticks", M_RING, M_RING});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    set_time(7, 30, 5);
    sb.push_back('{"auto_stop_5_ticks", M_RING | M_BUZ | M_LED, M_LED});
    step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_snooze();
    do_trigger();
    snooze = 1'b1;
    sb.push_back('{"snooze_led_on", M_RING | M_BUZ | M_LED, M_LED});
    step(); snooze = 1'b0;
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    for (int i = 1; i <= 9; i++) begin set_time(7, 30, i); step(); step(); end
    sb.push_back('{"snooze_9_ticks", M_RING | M_LED, M_LED});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    set_time(7, 30, 10);
    sb.push_back('{"snooze_rering", M_RING, M_RING});
    step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    stop = 1'b1;
    sb.push_back('{"stop_to_idle", M_RING | M_LED, M_LED});
    step(); stop = 1'b0;
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_priority();
    do_trigger();
    stop = 1'b1; snooze = 1'b1;
    step(); stop = 1'b0; snooze = 1'b0;
    for (int i = 1; i <= 12; i++) begin set_time(7, 30, i); step(); step(); end
    sb.push_back('{"stop_beats_snooze", M_RING | M_LED, M_LED});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end

    set_time(7, 29, 59); step(); step();
    set_mode = 1'b1; set_time(7, 30, 0);
    sb.push_back('{"set_beats_trigger", M_RING | M_LED, 19'h0});
    step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    step(); set_mode = 1'b0; step(); step();
    sb.push_back('{"no_pending_trigger", M_RING | M_LED, M_LED});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_disable();
    do_trigger();
    alarm_en = 1'b0;
    sb.push_back('{"disable_in_ring", M_RING | M_BUZ | M_LED, 19'h0});
    step();
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    set_time(7, 30, 1); step();
    alarm_en = 1'b1; step(); step();
    sb.push_back('{"reenable_idle", M_RING | M_LED, M_LED});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  task automatic test_reset_mid_ring();
    do_trigger();
    sb.push_back('{"ring_before_reset", M_RING, M_RING});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    reset = 1'b1;
    sb.push_back('{"async_reset_clears", M_ALL, 19'h0});
    #2;
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
    step(); reset = 1'b0;
    repeat (3) step();
    sb.push_back('{"post_reset_quiet", M_RING | M_BUZ | M_ALM, 19'h0});
    e = sb.pop_front(); n_chk++;
    if ((obs() & e.mask) !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs() & e.mask, e.val); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_trigger();
    test_snooze();
    test_priority();
    test_disable();
    test_reset_mid_ring();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TONE_HZ, default 2000, buzzer square-wave frequency.
REQ-003 Parameter BLINK_HZ, default 2, alarm_led blink frequency while ringing.
REQ-004 Parameter RING_SEC, default 60, seconds of ringing before auto-stop.
REQ-005 Parameter SNOOZE_SEC, default 300, snooze duration in seconds.
REQ-006 clk  in  1  system clock; the block has one clock, clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 h2, h1, m2, m1, s2, s1  in  4 each  current time in BCD from the clock core (tens/units of hours, minutes, seconds).
REQ-009 alarm_en  in  1  level; 1 = alarm armed.
REQ-010 set_mode  in  1  level; 1 = edit alarm time.
REQ-011 hr_up, min_up  in  1 each  single-cycle debounced increment pulses.
REQ-012 stop, snooze  in  1 each  single-cycle debounced pulses.
REQ-013 ah2, ah1, am2, am1  out  4 each  stored alarm time in BCD, for the seven-segment path.
REQ-014 ringing  out  1  high in RING.
REQ-015 buzzer  out  1  TONE_HZ square wave when ringing, else 0.
REQ-016 alarm_led  out  1  BLINK_HZ square wave when ringing, 1 in SNOOZE, alarm_en in IDLE, 0 in SET.

Function
REQ-017 FSM states: IDLE, SET, RING, SNOOZE; all state and outputs registered on clk.
REQ-018 Second tick = one-cycle pulse when s1 differs from its registered copy; the tick is suppressed on the first cycle after reset.
REQ-019 Match = alarm_en & {h2,h1,m2,m1} == {ah2,ah1,am2,am1} & {s2,s1} == 00; trigger = rising edge of match (registered), so one trigger per matching minute.
REQ-020 IDLE -> SET when set_mode=1; IDLE -> RING on trigger; SET priority over trigger in the same cycle.
REQ-021 SET: hr_up increments alarm hour BCD 00..23, wrapping 23 -> 00; min_up increments alarm minute 00..59, wrapping 59 -> 00 with no carry into hour; both pulses in one cycle apply both; SET -> IDLE when set_mode=0.
REQ-022 hr_up/min_up are ignored outside SET.
REQ-023 RING: ring counter cleared on entry and incremented per tick; -> IDLE on stop, or when the counter reaches RING_SEC; -> SNOOZE on snooze; stop wins over snooze in the same cycle.
REQ-024 SNOOZE: snooze counter cleared on entry and incremented per tick; -> RING when it reaches SNOOZE_SEC; -> IDLE on stop.
REQ-025 Any state except SET -> IDLE when alarm_en=0; set_mode=1 in RING or SNOOZE -> SET (cancels the alarm).
REQ-026 Tone and blink prescalers free-run from CLK_HZ/(2*TONE_HZ) and CLK_HZ/(2*BLINK_HZ) half-periods; counter widths are derived with clog2.
REQ-027 State transitions take effect one cycle after the causing input/tick; ringing asserts on the cycle after trigger.

Reset
REQ-028 reset (asynchronous): state IDLE; alarm time 00:00; counters, prescalers, edge registers 0; ringing, buzzer and alarm_led are 0.
REQ-029 Reset asserted mid-RING or mid-SET drops all outputs immediately, with no pending trigger kept.

Structure
REQ-030 A shared package holds the FSM state enum, BCD limits (23, 59) and the default parameter values.
REQ-031 One sub-module, alarm_tone_gen (parameterised prescaler producing the tone and blink square waves), is instantiated once.

Verification (CLK_HZ=1000, TONE_HZ=100, BLINK_HZ=10, RING_SEC=5, SNOOZE_SEC=10)
REQ-032 Set: set_mode=1, 7 hr_up, 30 min_up -> ah/am = 07:30; 60 further min_up -> 07:30; 17 further hr_up -> 00:30.
REQ-033 Trigger: alarm 07:30, enabled, time steps 07:29:59 -> 07:30:00 -> ringing=1 next cycle; buzzer toggles every 5 clks; auto-stop after 5 ticks.
REQ-034 Snooze: snooze pulse in RING -> SNOOZE with alarm_led=1; after 10 ticks ringing=1 again; stop then -> IDLE.
REQ-035 Priority: stop and snooze in the same cycle -> IDLE; trigger with set_mode=1 -> SET and no ringing.
REQ-036 alarm_en=0 during RING -> IDLE next cycle; reset mid-RING -> all outputs 0 asynchronously and alarm time 00:00.
